// File: rtl/reset_seq_pipe.sv
// Staggered reset release sequencer: synchronises the pin reset, holds, then releases N_OUT resets in order.
// Optional RST_SEQ_SW_ACK_EN adds a one-cycle sw_rst_ack pulse when a software-initiated sequence completes.
//
// state   | meaning
// --------+----------------------------------------------------------
// SYNC    | shifting 1s through the synchroniser after pin release
// HOLD    | all outputs asserted, counting MIN_HOLD edges
// RELEASE | releasing outputs 1..N_OUT-1, one every STAGGER edges
// DONE    | every output released, waiting for a software request
module reset_seq_pipe #(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_HOLD    = 4,
  parameter int STAGGER     = 3,
  parameter int N_OUT       = 3
) (
  input  logic             clk,
  input  logic             async_in_rst,
  input  logic             sw_rst_req,
  output logic [N_OUT-1:0] sync_out_rst,
  output logic             rst_done
`ifdef RST_SEQ_SW_ACK_EN
  ,
  output logic             sw_rst_ack
`endif
);

  localparam int CNT_MAX = (MIN_HOLD > STAGGER) ? MIN_HOLD : STAGGER;
  localparam int CW      = $clog2(CNT_MAX) + 1;
  localparam int IW      = $clog2(N_OUT) + 1;

  localparam logic [CW-1:0] HOLD_LAST = CW'(MIN_HOLD - 1);
  localparam logic [CW-1:0] STAG_LAST = CW'(STAGGER - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N_OUT - 1);

  typedef enum logic [1:0] {
    SYNC    = 2'd0,
    HOLD    = 2'd1,
    RELEASE = 2'd2,
    DONE    = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] chain_q, chain_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [N_OUT-1:0]       out_q, out_d;
  logic                   done_q, done_d;
  logic                   sw_take;

`ifdef RST_SEQ_SW_ACK_EN
  logic pend_q, pend_d;
  logic ack_q, ack_d;
`endif

  // Requests are only honoured once the synchroniser has released.
  assign sw_take = sw_rst_req && (state_q != SYNC);

  always_comb begin
    chain_d = {chain_q[SYNC_STAGES-2:0], 1'b1};
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    out_d   = out_q;
    done_d  = done_q;

    if (sw_take) begin
      state_d = HOLD;
      cnt_d   = '0;
      idx_d   = '0;
      out_d   = '0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        SYNC: begin
          if (chain_d[SYNC_STAGES-1]) begin
            state_d = HOLD;
            cnt_d   = '0;
          end
        end
        HOLD: begin
          if (chain_q[SYNC_STAGES-1]) begin
            if (cnt_q == HOLD_LAST) begin
              out_d[0] = 1'b1;
              cnt_d    = '0;
              if (N_OUT == 1) begin
                state_d = DONE;
                done_d  = 1'b1;
              end else begin
                state_d = RELEASE;
                idx_d   = IW'(1);
              end
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        RELEASE: begin
          if (cnt_q == STAG_LAST) begin
            for (int i = 1; i < N_OUT; i++) begin
              if (idx_q == IW'(i)) out_d[i] = 1'b1;
            end
            cnt_d = '0;
            if (idx_q == IDX_LAST) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef RST_SEQ_SW_ACK_EN
  // Pending flag distinguishes software-started sequences from pin power-up.
  always_comb begin
    pend_d = pend_q;
    ack_d  = 1'b0;
    if (sw_take) begin
      pend_d = 1'b1;
    end else if (done_d && !done_q && pend_q) begin
      ack_d  = 1'b1;
      pend_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or negedge async_in_rst) begin
    if (!async_in_rst) begin
      state_q <= SYNC;
      chain_q <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
`ifdef RST_SEQ_SW_ACK_EN
      pend_q  <= 1'b0;
      ack_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      chain_q <= chain_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      done_q  <= done_d;
`ifdef RST_SEQ_SW_ACK_EN
      pend_q  <= pend_d;
      ack_q   <= ack_d;
`endif
    end
  end

  assign sync_out_rst = out_q;
  assign rst_done     = done_q;
`ifdef RST_SEQ_SW_ACK_EN
  assign sw_rst_ack   = ack_q;
`endif

endmodule

// File: tb/tb_reset_seq_pipe.sv
// Bench for reset_seq_pipe: default instance plus a minimal single-output instance sharing stimulus.
module tb_reset_seq_pipe;

  logic       clk = 1'b0;
  logic       async_in_rst = 1'b0;
  logic       sw_rst_req = 1'b0;
  logic [2:0] out_a;
  logic       done_a;
  logic [0:0] out_b;
  logic       done_b;
`ifdef RST_SEQ_SW_ACK_EN
  logic       ack_a, ack_b;
`endif

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  reset_seq_pipe #(.SYNC_STAGES(2), .MIN_HOLD(4), .STAGGER(3), .N_OUT(3)) u_a (
    .clk(clk), .async_in_rst(async_in_rst), .sw_rst_req(sw_rst_req),
    .sync_out_rst(out_a), .rst_done(done_a)
`ifdef RST_SEQ_SW_ACK_EN
    , .sw_rst_ack(ack_a)
`endif
  );

  reset_seq_pipe #(.SYNC_STAGES(3), .MIN_HOLD(1), .STAGGER(1), .N_OUT(1)) u_b (
    .clk(clk), .async_in_rst(async_in_rst), .sw_rst_req(sw_rst_req),
    .sync_out_rst(out_b), .rst_done(done_b)
`ifdef RST_SEQ_SW_ACK_EN
    , .sw_rst_ack(ack_b)
`endif
  );

  // Reference model: edge count since pin release, and the edge that last started a hold window.
  int n;
  int base_a, base_b;
  bit sw_a, sw_b;

  always @(posedge clk or negedge async_in_rst) begin
    if (!async_in_rst) begin
      n      <= 0;
      base_a <= 2;
      base_b <= 3;
      sw_a   <= 1'b0;
      sw_b   <= 1'b0;
    end else begin
      n <= n + 1;
      if (sw_rst_req && (n + 1) > 2) begin base_a <= n + 1; sw_a <= 1'b1; end
      if (sw_rst_req && (n + 1) > 3) begin base_b <= n + 1; sw_b <= 1'b1; end
    end
  end

  function automatic int unsigned exp_bits(int e, int base, int mh, int st, int nout);
    int unsigned m = 0;
    for (int i = 0; i < nout; i++)
      if (e >= base + mh + i * st) m |= (32'd1 << i);
    return m;
  endfunction

  function automatic bit exp_ack(int e, int base, bit sw, int mh, int st, int nout);
    return sw && (e == base + mh + (nout - 1) * st);
  endfunction

  task automatic test_reset();
    async_in_rst = 1'b0;
    sw_rst_req   = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (out_a !== 3'b000) begin fails++; $display("FAIL rst_out_a got %b want 000", out_a); end
    checks++; if (done_a !== 1'b0) begin fails++; $display("FAIL rst_done_a got %b want 0", done_a); end
    checks++; if (out_b !== 1'b0) begin fails++; $display("FAIL rst_out_b got %b want 0", out_b); end
    checks++; if (done_b !== 1'b0) begin fails++; $display("FAIL rst_done_b got %b want 0", done_b); end
`ifdef RST_SEQ_SW_ACK_EN
    checks++; if (ack_a !== 1'b0 || ack_b !== 1'b0) begin fails++; $display("FAIL rst_ack got %b%b want 00", ack_a, ack_b); end
`endif
  endtask

  // Release the pin at a negedge and follow the fixed power-up timeline for 14 edges.
  task automatic test_powerup(input bit req_at_edge1);
    logic [2:0] ea;
    async_in_rst = 1'b1;
    sw_rst_req   = req_at_edge1;
    for (int e = 1; e <= 14; e++) begin
      @(negedge clk);
      sw_rst_req = 1'b0;
      ea = (e >= 12) ? 3'b111 : (e >= 9) ? 3'b011 : (e >= 6) ? 3'b001 : 3'b000;
      checks++; if (out_a !== ea) begin fails++; $display("FAIL pwr_out_a edge %0d got %b want %b", e, out_a, ea); end
      checks++; if (done_a !== (e >= 12)) begin fails++; $display("FAIL pwr_done_a edge %0d got %b want %b", e, done_a, e >= 12); end
      checks++; if (out_b !== 1'(e >= 4)) begin fails++; $display("FAIL pwr_out_b edge %0d got %b want %b", e, out_b, e >= 4); end
      checks++; if (done_b !== (e >= 4)) begin fails++; $display("FAIL pwr_done_b edge %0d got %b want %b", e, done_b, e >= 4); end
`ifdef RST_SEQ_SW_ACK_EN
      checks++; if (ack_a !== 1'b0 || ack_b !== 1'b0) begin fails++; $display("FAIL pwr_ack edge %0d got %b%b want 00", e, ack_a, ack_b); end
`endif
    end
  endtask

  // Pin drop between edges 10 and 11 with no clock edge must clear everything at once.
  task automatic test_async_mid();
    async_in_rst = 1'b0;
    @(negedge clk);
    async_in_rst = 1'b1;
    repeat (10) @(negedge clk);
    #2 async_in_rst = 1'b0;
    #1;
    checks++; if (out_a !== 3'b000) begin fails++; $display("FAIL mid_out_a got %b want 000", out_a); end
    checks++; if (done_a !== 1'b0) begin fails++; $display("FAIL mid_done_a got %b want 0", done_a); end
    checks++; if (out_b !== 1'b0) begin fails++; $display("FAIL mid_out_b got %b want 0", out_b); end
    @(negedge clk);
  endtask

  // Single request from DONE at edge E; k counts edges after E.
  task automatic test_sw_pulse();
    logic [2:0] ea;
    sw_rst_req = 1'b1;
    @(negedge clk);
    sw_rst_req = 1'b0;
    checks++; if (out_a !== 3'b000 || done_a !== 1'b0) begin fails++; $display("FAIL swp_clear_a got %b/%b want 000/0", out_a, done_a); end
    checks++; if (out_b !== 1'b0 || done_b !== 1'b0) begin fails++; $display("FAIL swp_clear_b got %b/%b want 0/0", out_b, done_b); end
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      ea = {k >= 10, k >= 7, k >= 4};
      checks++; if (out_a !== ea) begin fails++; $display("FAIL swp_out_a E+%0d got %b want %b", k, out_a, ea); end
      checks++; if (done_a !== (k >= 10)) begin fails++; $display("FAIL swp_done_a E+%0d got %b want %b", k, done_a, k >= 10); end
      checks++; if (out_b !== 1'b1 || done_b !== 1'b1) begin fails++; $display("FAIL swp_b E+%0d got %b/%b want 1/1", k, out_b, done_b); end
`ifdef RST_SEQ_SW_ACK_EN
      checks++; if (ack_a !== (k == 10)) begin fails++; $display("FAIL swp_ack_a E+%0d got %b want %b", k, ack_a, k == 10); end
      checks++; if (ack_b !== (k == 1)) begin fails++; $display("FAIL swp_ack_b E+%0d got %b want %b", k, ack_b, k == 1); end
`endif
    end
  endtask

  // Requests at E and E+2: the second one restarts the hold window.
  task automatic test_sw_double();
    logic [2:0] ea;
    sw_rst_req = 1'b1;
    @(negedge clk);
    sw_rst_req = 1'b0;
    @(negedge clk);
    sw_rst_req = 1'b1;
    @(negedge clk);
    sw_rst_req = 1'b0;
    for (int k = 3; k <= 13; k++) begin
      @(negedge clk);
      ea = {k >= 12, k >= 9, k >= 6};
      checks++; if (out_a !== ea) begin fails++; $display("FAIL swd_out_a E+%0d got %b want %b", k, out_a, ea); end
      checks++; if (done_a !== (k >= 12)) begin fails++; $display("FAIL swd_done_a E+%0d got %b want %b", k, done_a, k >= 12); end
    end
  endtask

  // Random requests and pin drops checked every cycle against the model.
  task automatic test_random();
    logic [2:0] ea;
    logic [0:0] eb;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      ea = 3'(exp_bits(n, base_a, 4, 3, 3));
      eb = 1'(exp_bits(n, base_b, 1, 1, 1));
      checks++; if (out_a !== ea) begin fails++; $display("FAIL rnd_out_a cyc %0d got %b want %b", c, out_a, ea); end
      checks++; if (done_a !== (ea == 3'b111)) begin fails++; $display("FAIL rnd_done_a cyc %0d got %b want %b", c, done_a, ea == 3'b111); end
      checks++; if (out_b !== eb || done_b !== eb[0]) begin fails++; $display("FAIL rnd_b cyc %0d got %b/%b want %b", c, out_b, done_b, eb); end
`ifdef RST_SEQ_SW_ACK_EN
      checks++; if (ack_a !== exp_ack(n, base_a, sw_a, 4, 3, 3)) begin fails++; $display("FAIL rnd_ack_a cyc %0d got %b", c, ack_a); end
      checks++; if (ack_b !== exp_ack(n, base_b, sw_b, 1, 1, 1)) begin fails++; $display("FAIL rnd_ack_b cyc %0d got %b", c, ack_b); end
`endif
      sw_rst_req = ($urandom_range(0, 11) == 0);
      if (async_in_rst && $urandom_range(0, 79) == 0) begin
        async_in_rst = 1'b0;
        #1;
        checks++; if (out_a !== 3'b000 || done_a !== 1'b0 || out_b !== 1'b0) begin fails++; $display("FAIL rnd_async cyc %0d got %b/%b/%b", c, out_a, done_a, out_b); end
      end else begin
        async_in_rst = 1'b1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_powerup(1'b0);
    test_async_mid();
    test_powerup(1'b0);
    test_sw_pulse();
    test_sw_double();
    test_reset();
    test_powerup(1'b1);
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
